// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// control-bundle field order and the stall down-counter width helper.
package hazard_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LSTALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                       ex_mem_write: 1'b1, mem_wb_write: 1'b1,
                                       if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0};

  // Width of the stall down-counter: enough to hold LOAD_STALL-1 plus headroom.
  function automatic int rem_width(input int load_stall);
    return $clog2(load_stall) + 1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != {CNT_W{1'b1}})) begin
      q_d = q_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: memory freeze, MEM-stage redirect flush and
// multi-cycle load-use stall, with saturating stall/flush event counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rt_addr,
  input  logic              ex_memread,
  input  logic              mem_branch_taken,
  input  logic              mem_jump,
  input  logic              dmem_busy,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              ex_mem_write,
  output logic              mem_wb_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int REM_W = rem_width(LOAD_STALL);
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_STALL - 1);
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

  hz_state_e        state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  hz_ctrl_t         ctrl;
  logic             load_use, redir, stall_inc, flush_inc;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign load_use = ex_memread && (ex_rt_addr != '0) &&
                    ((ex_rt_addr == id_rs_addr) || (id_uses_rt && (ex_rt_addr == id_rt_addr)));
  assign redir    = mem_branch_taken || mem_jump;

  always_comb begin
    ctrl      = CTRL_NORMAL;
    state_d   = state_q;
    rem_d     = rem_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst_i) begin
      if (dmem_busy) begin
        ctrl = '0;
      end else if (redir) begin
        ctrl.if_id_flush  = 1'b1;
        ctrl.id_ex_flush  = 1'b1;
        ctrl.ex_mem_flush = 1'b1;
        state_d           = IDLE;
        rem_d             = '0;
        flush_inc         = 1'b1;
      end else if ((state_q == LSTALL) || load_use) begin
        ctrl.pc_write    = 1'b0;
        ctrl.if_id_write = 1'b0;
        ctrl.id_ex_flush = 1'b1;
        stall_inc        = 1'b1;
        if (state_q == IDLE) begin
          // A single-cycle stall is covered entirely by the detection cycle.
          if (LOAD_STALL > 1) begin
            state_d = LSTALL;
            rem_d   = REM_INIT;
          end
        end else begin
          rem_d = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign id_ex_write  = ctrl.id_ex_write;
  assign ex_mem_write = ctrl.ex_mem_write;
  assign mem_wb_write = ctrl.mem_wb_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_flush = ctrl.ex_mem_flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (stall_inc),
    .q     (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (flush_inc),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three instances share stimulus
// (LOAD_STALL=1, LOAD_STALL=3, and a 4-bit-counter variant).
module tb_hazard_ctrl_unit;

  localparam int AW = 5;
  // Bundle order: pc, if_id_w, id_ex_w, ex_mem_w, mem_wb_w, if_id_f, id_ex_f, ex_mem_f
  localparam logic [7:0] NORMAL = 8'b11111_000;
  localparam logic [7:0] STALL  = 8'b00111_010;
  localparam logic [7:0] REDIR  = 8'b11111_111;
  localparam logic [7:0] FREEZE = 8'b00000_000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_memread, br, jmp, busy;
  logic [7:0]    ctrl_a, ctrl_b, ctrl_c;
  logic [15:0]   sc_a, fc_a, sc_b, fc_b;
  logic [3:0]    sc_c, fc_c;
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(AW), .LOAD_STALL(1), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .id_rs_addr(id_rs), .id_rt_addr(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt_addr(ex_rt), .ex_memread(ex_memread), .mem_branch_taken(br), .mem_jump(jmp),
    .dmem_busy(busy), .pc_write(ctrl_a[7]), .if_id_write(ctrl_a[6]), .id_ex_write(ctrl_a[5]),
    .ex_mem_write(ctrl_a[4]), .mem_wb_write(ctrl_a[3]), .if_id_flush(ctrl_a[2]),
    .id_ex_flush(ctrl_a[1]), .ex_mem_flush(ctrl_a[0]), .stall_cnt(sc_a), .flush_cnt(fc_a));

  hazard_ctrl_unit #(.REG_AW(AW), .LOAD_STALL(3), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .id_rs_addr(id_rs), .id_rt_addr(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt_addr(ex_rt), .ex_memread(ex_memread), .mem_branch_taken(br), .mem_jump(jmp),
    .dmem_busy(busy), .pc_write(ctrl_b[7]), .if_id_write(ctrl_b[6]), .id_ex_write(ctrl_b[5]),
    .ex_mem_write(ctrl_b[4]), .mem_wb_write(ctrl_b[3]), .if_id_flush(ctrl_b[2]),
    .id_ex_flush(ctrl_b[1]), .ex_mem_flush(ctrl_b[0]), .stall_cnt(sc_b), .flush_cnt(fc_b));

  hazard_ctrl_unit #(.REG_AW(AW), .LOAD_STALL(1), .CNT_W(4)) dut_c (
    .clk_i(clk), .rst_i(rst_n), .id_rs_addr(id_rs), .id_rt_addr(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt_addr(ex_rt), .ex_memread(ex_memread), .mem_branch_taken(br), .mem_jump(jmp),
    .dmem_busy(busy), .pc_write(ctrl_c[7]), .if_id_write(ctrl_c[6]), .id_ex_write(ctrl_c[5]),
    .ex_mem_write(ctrl_c[4]), .mem_wb_write(ctrl_c[3]), .if_id_flush(ctrl_c[2]),
    .id_ex_flush(ctrl_c[1]), .ex_mem_flush(ctrl_c[0]), .stall_cnt(sc_c), .flush_cnt(fc_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic ur,
                        input logic [AW-1:0] xrt, input logic mr, input logic b,
                        input logic j, input logic bz);
    id_rs = rs; id_rt = rt; id_uses_rt = ur; ex_rt = xrt;
    ex_memread = mr; br = b; jmp = j; busy = bz;
  endtask

  // One cycle: inputs change on the falling edge, outputs sampled 1ns later.
  task automatic step(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic ur,
                      input logic [AW-1:0] xrt, input logic mr, input logic b,
                      input logic j, input logic bz);
    @(negedge clk);
    set_in(rs, rt, ur, xrt, mr, b, j, bz);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset forces NORMAL controls even with hazard and busy inputs present
    rst_n = 1'b0;
    set_in(8, 0, 0, 8, 1, 0, 0, 1);
    #2;
    chk("rst_ctrl_a_busy", ctrl_a, NORMAL);
    chk("rst_ctrl_b_busy", ctrl_b, NORMAL);
    busy = 1'b0;
    #1;
    chk("rst_ctrl_b_hz", ctrl_b, NORMAL);
    chk("rst_sc_b", sc_b, 0);
    chk("rst_fc_c", fc_c, 0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Single load-use hazard: 1 stall cycle for LOAD_STALL=1, 3 for LOAD_STALL=3
    step(8, 0, 0, 8, 1, 0, 0, 0);
    chk("s1_a_c1", ctrl_a, STALL);
    chk("s1_b_c1", ctrl_b, STALL);
    chk("s1_c_c1", ctrl_c, STALL);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s1_a_c2", ctrl_a, NORMAL);
    chk("s1_b_c2", ctrl_b, STALL);
    chk("s1_sc_a_c2", sc_a, 1);
    chk("s1_sc_b_c2", sc_b, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s1_b_c3", ctrl_b, STALL);
    chk("s1_sc_b_c3", sc_b, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s1_b_c4", ctrl_b, NORMAL);
    chk("s1_sc_b_c4", sc_b, 3);
    chk("s1_sc_a_c4", sc_a, 1);

    // Hazard held through LSTALL must not extend the stall
    for (int k = 0; k < 3; k++) begin
      step(8, 0, 0, 8, 1, 0, 0, 0);
      chk("s2_b_held", ctrl_b, STALL);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s2_b_after", ctrl_b, NORMAL);
    chk("s2_sc_b", sc_b, 6);
    chk("s2_sc_a", sc_a, 4);

    // Register 0 and an unused rt never stall; a used rt match does
    step(0, 0, 0, 0, 1, 0, 0, 0);
    chk("s3_r0_a", ctrl_a, NORMAL);
    chk("s3_r0_b", ctrl_b, NORMAL);
    step(3, 5, 0, 5, 1, 0, 0, 0);
    chk("s3_rt_unused_a", ctrl_a, NORMAL);
    chk("s3_rt_unused_b", ctrl_b, NORMAL);
    step(3, 5, 1, 5, 1, 0, 0, 0);
    chk("s3_rt_used_a", ctrl_a, STALL);
    chk("s3_rt_used_b", ctrl_b, STALL);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s3_sc_a", sc_a, 5);
    chk("s3_drain1_b", ctrl_b, STALL);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s3_drain2_b", ctrl_b, STALL);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s3_done_b", ctrl_b, NORMAL);
    chk("s3_sc_b", sc_b, 9);

    // Jump in the 2nd stall cycle aborts LSTALL
    pulse_reset();
    step(8, 0, 0, 8, 1, 0, 0, 0);
    chk("s4_b_c1", ctrl_b, STALL);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("s4_b_jmp", ctrl_b, REDIR);
    chk("s4_a_jmp", ctrl_a, REDIR);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s4_b_after", ctrl_b, NORMAL);
    chk("s4_fc_b", fc_b, 1);
    chk("s4_sc_b", sc_b, 1);

    // Freeze for 4 cycles inside LSTALL (rem=2), with a branch masked by busy
    pulse_reset();
    step(8, 0, 0, 8, 1, 0, 0, 0);
    chk("s5_b_c1", ctrl_b, STALL);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("s5_b_frz1", ctrl_b, FREEZE);
    chk("s5_a_frz1", ctrl_a, FREEZE);
    chk("s5_sc_b_frz1", sc_b, 1);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    chk("s5_b_frz_br", ctrl_b, FREEZE);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("s5_b_frz3", ctrl_b, FREEZE);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("s5_b_frz4", ctrl_b, FREEZE);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s5_b_rel1", ctrl_b, STALL);
    chk("s5_sc_b_rel1", sc_b, 1);
    chk("s5_fc_b_rel1", fc_b, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s5_b_rel2", ctrl_b, STALL);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s5_b_done", ctrl_b, NORMAL);
    chk("s5_sc_b_done", sc_b, 3);

    // 20 redirects (alternating branch/jump) saturate a 4-bit counter at 15
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0, i[0], ~i[0], 0);
      if (i < 2) chk("s6_c_redir", ctrl_c, REDIR);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s6_fc_c_sat", fc_c, 15);
    chk("s6_fc_a", fc_a, 20);
    step(8, 0, 0, 8, 1, 0, 0, 0);
    chk("s6_b_stall", ctrl_b, STALL);

    // Asynchronous reset mid-LSTALL clears counters at once
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_arst_fc_c", fc_c, 0);
    chk("s6_arst_fc_a", fc_a, 0);
    chk("s6_arst_sc_b", sc_b, 0);
    chk("s6_arst_ctrl_b", ctrl_b, NORMAL);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s6_post_rst_b", ctrl_b, NORMAL);
    chk("s6_post_rst_sc_b", sc_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
